// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state (IDLE/READ/EXEC/WB) instruction sequencer that
// steers a register file and an external ALU for one 16-bit instruction.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   instr_valid, instr    instruction offer {ot,opcode,rd,ra,rb,wb_en}
//   instr_ready           high in IDLE (accept when valid & ready)
//   rf_re, rf_ra, rf_rb   register-file read strobe/addresses (READ)
//   alu_ot, alu_opcode    ALU controls taken from the instruction register
//   alu_out, flags_in     ALU result/flags, sampled at the end of EXEC
//   rf_we, rf_wa, rf_wd   register-file write port (WB)
//   flags                 architectural flags {za,zb,eq,gt,lt}
//   busy, done, err       in-flight, completion pulse, illegal-op pulse
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic        rf_re,
    output logic [2:0]  rf_ra,
    output logic [2:0]  rf_rb,
    output logic [1:0]  alu_ot,
    output logic [3:0]  alu_opcode,
    input  logic [15:0] alu_out,
    input  logic [4:0]  flags_in,
    output logic        rf_we,
    output logic [2:0]  rf_wa,
    output logic [15:0] rf_wd,
    output logic [4:0]  flags,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ir;
    logic [15:0] result;
    logic        illegal;

    // ot = 11 has no ALU meaning: no writeback, no flag update
    assign illegal    = (ir[15:14] == 2'b11);

    assign alu_ot     = ir[15:14];
    assign alu_opcode = ir[13:10];
    assign rf_wa      = ir[9:7];
    assign rf_ra      = ir[6:4];
    assign rf_rb      = ir[3:1];
    assign rf_wd      = result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ir     <= 16'h0000;
            result <= 16'h0000;
            flags  <= 5'b00000;
        end else begin
            state <= state_nxt;
            if (state == IDLE && instr_valid) begin
                ir <= instr;
            end
            if (state == EXEC) begin
                result <= alu_out;
                if (!illegal) begin
                    flags <= flags_in;
                end
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        rf_re       = 1'b0;
        rf_we       = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        busy        = 1'b0;
        unique case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                busy      = 1'b1;
                rf_re     = 1'b1;
                state_nxt = EXEC;
            end
            EXEC: begin
                busy      = 1'b1;
                state_nxt = WB;
            end
            WB: begin
                busy      = 1'b1;
                done      = 1'b1;
                err       = illegal;
                rf_we     = ir[0] && !illegal;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
